// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: 2-entry op FIFO, head opcode -> ALU control decode,
// valid/ready output handshake, committed NZVC flags and branch-condition outputs.
module alu_issue_ctrl #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] in_opcode,
  input  logic        in_sign,
  input  logic        in_alu_on,
  input  logic        flush,
  output logic [2:0]  alu_cntrl,
  input  logic [3:0]  alu_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] out_opcode,
  output logic        out_illegal,
  output logic [3:0]  flags_q,
  output logic        cond_lt,
  output logic        cond_zero
);

  // state | meaning
  // EMPTY | no buffered ops, out_valid low
  // ONE   | one op buffered, it is the head
  // FULL  | two ops buffered, in_ready low
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] opcode_q [DEPTH];
  logic        sign_q   [DEPTH];
  logic        alu_on_q [DEPTH];
  logic        wr_ptr, rd_ptr;
  logic        push, pop;
  logic        flag_op;
  logic [10:0] head_opcode;
  logic        head_sign, head_alu_on;

  assign in_ready    = (state_q != FULL);
  assign out_valid   = (state_q != EMPTY);
  assign push        = in_valid & in_ready & ~flush;
  assign pop         = out_valid & out_ready & ~flush;
  assign head_opcode = opcode_q[rd_ptr];
  assign head_sign   = sign_q[rd_ptr];
  assign head_alu_on = alu_on_q[rd_ptr];
  assign out_opcode  = out_valid ? head_opcode : 11'd0;
  assign cond_lt     = flags_q[3] ^ flags_q[1];
  assign cond_zero   = alu_flags[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      flags_q <= 4'b0000;
      for (int i = 0; i < DEPTH; i++) begin
        opcode_q[i] <= 11'd0;
        sign_q[i]   <= 1'b0;
        alu_on_q[i] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      if (flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) begin
          opcode_q[wr_ptr] <= in_opcode;
          sign_q[wr_ptr]   <= in_sign;
          alu_on_q[wr_ptr] <= in_alu_on;
          wr_ptr           <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
          if (flag_op) flags_q <= alu_flags;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (push) state_d = ONE;
        ONE: begin
          if (push && !pop)      state_d = FULL;
          else if (pop && !push) state_d = EMPTY;
        end
        FULL:    if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Priority decode of the head entry; only ADDS/SUBS are allowed to commit flags.
  always_comb begin
    alu_cntrl   = 3'b000;
    out_illegal = 1'b0;
    flag_op     = 1'b0;
    if (out_valid && head_alu_on) begin
      if (head_opcode[10:1] == 10'b1001000100) begin
        alu_cntrl = 3'b010;
      end else if (head_opcode == 11'b10101011000) begin
        alu_cntrl = 3'b010;
        flag_op   = 1'b1;
      end else if (head_opcode == 11'b11111000000 || head_opcode == 11'b11111000010) begin
        alu_cntrl = {2'b01, head_sign};
      end else if (head_opcode == 11'b11101011000) begin
        alu_cntrl = 3'b011;
        flag_op   = 1'b1;
      end else if (head_opcode[10:5] == 6'b100101) begin
        alu_cntrl = 3'b010;
      end else if (head_opcode == 11'b11010110000 || head_opcode[10:3] == 8'b10110100 ||
                   head_opcode[10:3] == 8'b01010100) begin
        alu_cntrl = 3'b000;
      end else begin
        out_illegal = 1'b1;
      end
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Execute-stage issue controller sitting between the ID/EX pipeline register and the shared combinational ALU. It buffers up to two decoded operations in a 2-entry FIFO, decodes the head entry's opcode into the 3-bit ALU control, and presents ALU results downstream with a valid/ready handshake. It owns the architectural NZVC flag register, committing it only when ADDS/SUBS retire, and evaluates B.LT/CBZ conditions for the branch unit.

## Interface
Parameters:
- DEPTH, 2, FIFO entries; only 2 is supported.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  upstream has an op
- in_ready  out  1  FIFO can accept (count < 2)
- in_opcode  in  11  instruction opcode bits [31:21]
- in_sign  in  1  LDUR/STUR offset sign (1 = subtract)
- in_alu_on  in  1  op requires ALU
- flush  in  1  discard all buffered ops (branch mispredict)
- alu_cntrl  out  3  ALU control for head entry
- alu_flags  in  4  {negative, zero, overflow, carry_out} from ALU, combinational on alu_cntrl
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_opcode  out  11  head entry opcode
- out_illegal  out  1  head entry is ALU_on with unsupported opcode
- flags_q  out  4  committed {N,Z,V,C}
- cond_lt  out  1  flags_q[N] ^ flags_q[V]
- cond_zero  out  1  alu_flags zero for head entry (CBZ)

## Operation
- Entry fields: opcode, sign, alu_on. Write pointer, read pointer (1 bit each), count (0..2).
- Push = in_valid & in_ready & !flush. Pop = out_valid & out_ready & !flush.
- Push and pop same cycle with count=1 or 2: count unchanged; with count=2, in_ready is 0 so no push.
- Decode of head (priority order, alu_on=1):
  - ADDI (opcode[10:1]=1001000100) or ADDS (10101011000) -> 010
  - STUR (11111000000) / LDUR (11111000010) -> {2'b01, sign}
  - SUBS (11101011000) -> 011
  - BL (opcode[10:5]=100101) -> 010
  - BR (11010110000), CBZ (opcode[10:3]=10110100), B.LT (opcode[10:3]=01010100) -> 000
  - otherwise -> 000, out_illegal=1
- alu_on=0 or FIFO empty: alu_cntrl=000, out_illegal=0 (never X).
- Flag commit: on pop, if head is ADDS or SUBS (alu_on=1), flags_q <= alu_flags. ADDI, LDUR, STUR, illegal and alu_on=0 ops never write flags_q.
- flush: count, pointers -> 0 next edge; no flag commit that cycle even if out_ready; flush overrides push.
- States (derived from count): EMPTY (0), ONE (1), FULL (2). EMPTY->ONE on push; ONE->FULL push&!pop; ONE->EMPTY pop&!push; FULL->ONE pop; any->EMPTY on flush.

## Timing
- Reset values: in_ready=1, out_valid=0, alu_cntrl=000, out_opcode=0, out_illegal=0, flags_q=0000, cond_lt=0, cond_zero=alu_flags[2] pass-through.
- Latency: op pushed at edge N is head and out_valid=1 after edge N when FIFO was empty; alu_cntrl valid same cycle (combinational from head).
- Back-to-back SUBS then B.LT: SUBS flags committed at its pop edge; B.LT as next head sees updated cond_lt with zero bubble.
- Stall: out_ready=0 holds head, alu_cntrl and outputs stable; flags_q unchanged.
- in_ready depends only on registered count (no comb path from out_ready).
- Reset asserted mid-operation: entries dropped, flags_q cleared immediately (asynchronous).

## Test plan
- Reset then push ADDS, out_ready=1, alu_flags=1000 -> alu_cntrl=010 while head, flags_q=1000 after pop, cond_lt=1.
- Push SUBS (alu_flags=0010) then B.LT back-to-back -> SUBS alu_cntrl=011, B.LT head sees flags_q=0010, cond_lt=1, alu_cntrl=000.
- out_ready=0, push 3 ops -> in_ready=0 after 2nd; 3rd held upstream; release -> pops in order, no loss.
- LDUR sign=1 then STUR sign=0, ADDI with alu_flags=0100 -> alu_cntrl 011, 010, 010; flags_q unchanged.
- Head SUBS with flush and out_ready=1 same cycle -> FIFO empty next cycle, flags_q unchanged; opcode 11111111111 alu_on=1 -> out_illegal=1, alu_cntrl=000.
- Assert reset with 2 entries and flags_q=1111 -> out_valid=0, in_ready=1, flags_q=0000 before next edge.
